ex_mem_reg: RTL
===============

Name: ex_mem_reg

Overview:
- Pipeline register between the EX stage and the MEM stage of the 5-stage ARM pipeline.
- Captures EX results and the memory/writeback control set, and inserts bubbles on flush.
- Holds its contents on stall.
- Owns the architectural NZCV condition-flag register, which is updated by S-bit instructions, and a retired-into-MEM instruction counter for debug/perf.

Parameters:
- DATA_W, 32, width of ALU result, store data and counter.
- REG_ADDR_W, 4, width of destination register index.

Ports:
- clk  input  1  pipeline clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold all contents (hazard unit).
- flush  input  1  replace incoming instruction with bubble.
- valid_in  input  1  EX holds a real instruction.
- reg_write_enable_in  input  1  writeback enable.
- mem_enable_in  input  1  data memory access enable.
- mem_rw_in  input  1  1 = write, 0 = read.
- mem_to_reg_select_in  input  1  writeback source is memory.
- mem_size_in  input  1  1 = word, 0 = byte.
- status_bit_in  input  1  instruction's S bit.
- alu_flags_in  input  4  NZCV produced by ALU, bit3 = N.
- alu_result_in  input  DATA_W  ALU result / memory address.
- store_data_in  input  DATA_W  store data (EX reg C value).
- reg_dst_in  input  REG_ADDR_W  destination register.
- valid_out  output  1  MEM holds a real instruction.
- reg_write_enable_out, mem_enable_out, mem_rw_out, mem_to_reg_select_out, mem_size_out  output  1 each  registered controls.
- alu_result_out  output  DATA_W  registered.
- store_data_out  output  DATA_W  registered.
- reg_dst_out  output  REG_ADDR_W  registered.
- flags_out  output  4  architectural NZCV register.
- instr_count  output  DATA_W  count of valid instructions loaded.

Behaviour:
- Priority per rising edge: reset > flush > stall > load.
- Reset:
  - All outputs go to 0: valid_out, every control output, alu_result_out, store_data_out, reg_dst_out, flags_out = 4'b0000, instr_count = 0.
  - Reset applied mid-stall or mid-flush wins unconditionally.
- Load (no reset, flush or stall):
  - All *_out take their *_in values one cycle later.
  - valid_out <= valid_in.
- Bubble gating: if valid_in = 0 on load, the control outputs (reg_write_enable_out, mem_enable_out, mem_rw_out, mem_to_reg_select_out, mem_size_out) are forced to 0. Data outputs still load.
- Flush:
  - valid_out and all control outputs go to 0.
  - Data outputs (alu_result_out, store_data_out, reg_dst_out) hold their previous values.
  - flags_out and instr_count are not updated.
  - flush together with stall: flush wins, and the bubble is inserted.
- Stall: every output, including flags_out and instr_count, holds its value.
- Flag register:
  - flags_out <= alu_flags_in only on a load cycle with valid_in = 1 and status_bit_in = 1. Otherwise it holds.
  - Flushed, stalled or bubble instructions never modify flags.
- Counter:
  - instr_count increments by 1 on each load cycle with valid_in = 1.
  - Wraps modulo 2^DATA_W: 0xFFFFFFFF -> 0x00000000, with no saturation and no sticky overflow.
- Latency: exactly 1 cycle from input to output. There is no combinational path from any input to any output.
- No initial blocks; reset is the only initialisation mechanism.

Decomposition:
- Shared package pipe_pkg holds:
  - flag bit index constants FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0;
  - MEM_SIZE_BYTE = 0 and MEM_SIZE_WORD = 1;
  - MEM_READ = 0 and MEM_WRITE = 1.
- One sub-module is natural: flag_reg, which contains the NZCV register and its qualified update enable. It is reused later by the conditional-execution check in ID.
- The counter and the pipeline fields stay inline.

Test Plan:
- Reset: assert reset for 2 cycles with all inputs at 1 -> every output is 0 and flags_out = 0000.
- Normal pass: valid_in = 1, alu_result_in = 0x0000_1004, store_data_in = 0xDEAD_BEEF, reg_dst_in = 5, mem_enable_in = 1, mem_rw_in = 1 -> next cycle the outputs match and instr_count = 1.
- Stall hold: load A, then stall for 3 cycles with different inputs B -> outputs stay A and instr_count is unchanged. Release stall -> B appears one cycle later.
- Flush with S bit: valid_in = 1, status_bit_in = 1, alu_flags_in = 1010, flush = 1 -> valid_out = 0, controls 0, flags_out unchanged (0000), instr_count unchanged.
- Flag update: status_bit_in = 1, alu_flags_in = 0110, valid -> flags_out = 0110. Then status_bit_in = 0, alu_flags_in = 1111 -> flags_out stays 0110.
- Simultaneous flush and stall, then counter wrap:
  - flush = stall = 1 -> bubble is inserted.
  - Preload instr_count to 0xFFFF_FFFF via 2^32-1 valid loads (force in sim), then one valid load -> instr_count = 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: NZCV bit positions, memory size and direction codes.
package pipe_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic MEM_SIZE_BYTE = 1'b0;
  localparam logic MEM_SIZE_WORD = 1'b1;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef logic [3:0] nzcv_t;

endpackage

// File: rtl/flag_reg.sv
// Architectural NZCV register with a single qualified update enable.
module flag_reg
  import pipe_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  upd_en_i,
  input  nzcv_t flags_i,
  output nzcv_t flags_o
);

  nzcv_t flags_q;
  nzcv_t flags_d;

  always_comb begin
    flags_d = flags_q;
    if (upd_en_i) flags_d = flags_i;
  end

  always_ff @(posedge clk) begin
    if (reset) flags_q <= '0;
    else       flags_q <= flags_d;
  end

  assign flags_o = flags_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: stall/flush control, bubble gating,
// NZCV ownership and a retired-into-MEM instruction counter.
module ex_mem_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic                  reg_write_enable_in,
  input  logic                  mem_enable_in,
  input  logic                  mem_rw_in,
  input  logic                  mem_to_reg_select_in,
  input  logic                  mem_size_in,
  input  logic                  status_bit_in,
  input  logic [3:0]            alu_flags_in,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [DATA_W-1:0]     store_data_in,
  input  logic [REG_ADDR_W-1:0] reg_dst_in,
  output logic                  valid_out,
  output logic                  reg_write_enable_out,
  output logic                  mem_enable_out,
  output logic                  mem_rw_out,
  output logic                  mem_to_reg_select_out,
  output logic                  mem_size_out,
  output logic [DATA_W-1:0]     alu_result_out,
  output logic [DATA_W-1:0]     store_data_out,
  output logic [REG_ADDR_W-1:0] reg_dst_out,
  output logic [3:0]            flags_out,
  output logic [DATA_W-1:0]     instr_count
);

  typedef struct packed {
    logic we;
    logic men;
    logic rw;
    logic m2r;
    logic size;
  } ctl_t;

  logic                  load;
  ctl_t                  ctl_in;
  logic                  valid_q, valid_d;
  ctl_t                  ctl_q, ctl_d;
  logic [DATA_W-1:0]     alu_q, alu_d;
  logic [DATA_W-1:0]     sd_q, sd_d;
  logic [REG_ADDR_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0]     cnt_q, cnt_d;

  assign load   = !flush && !stall;
  assign ctl_in = '{we:   reg_write_enable_in,
                    men:  mem_enable_in,
                    rw:   mem_rw_in,
                    m2r:  mem_to_reg_select_in,
                    size: mem_size_in};

  always_comb begin
    valid_d = valid_q;
    ctl_d   = ctl_q;
    alu_d   = alu_q;
    sd_d    = sd_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    if (flush) begin
      // Bubble: kill control, leave data fields as they were
      valid_d = 1'b0;
      ctl_d   = '0;
    end else if (!stall) begin
      valid_d = valid_in;
      ctl_d   = valid_in ? ctl_in : '0;
      alu_d   = alu_result_in;
      sd_d    = store_data_in;
      dst_d   = reg_dst_in;
      if (valid_in) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctl_q   <= '0;
      alu_q   <= '0;
      sd_q    <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctl_q   <= ctl_d;
      alu_q   <= alu_d;
      sd_q    <= sd_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
    end
  end

  flag_reg u_flags (
    .clk      (clk),
    .reset    (reset),
    .upd_en_i (load && valid_in && status_bit_in),
    .flags_i  (alu_flags_in),
    .flags_o  (flags_out)
  );

  assign valid_out             = valid_q;
  assign reg_write_enable_out  = ctl_q.we;
  assign mem_enable_out        = ctl_q.men;
  assign mem_rw_out            = ctl_q.rw;
  assign mem_to_reg_select_out = ctl_q.m2r;
  assign mem_size_out          = ctl_q.size;
  assign alu_result_out        = alu_q;
  assign store_data_out        = sd_q;
  assign reg_dst_out           = dst_q;
  assign instr_count           = cnt_q;

endmodule
